lc2k_inst_encoder: RTL and testbench

LC2K_INST_ENCODER -- requirements
Module: lc2k_inst_encoder

---
 rtl/lc2k_pkg.sv | 34 +++
 rtl/lc2k_field_packer.sv | 35 +++
 rtl/lc2k_inst_encoder.sv | 119 +++++++++++
 tb/tb_lc2k_inst_encoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc2k_pkg.sv
// Shared LC2K definitions: opcodes, instruction field positions and encoder FSM states.
package lc2k_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NOR  = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_JALR = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_NOOP = 3'b111;

    localparam int OPCODE_LSB = 22;
    localparam int OPCODE_W   = 3;
    localparam int REGA_LSB   = 19;
    localparam int REGB_LSB   = 16;
    localparam int DEST_LSB   = 0;
    localparam int REG_W      = 3;
    localparam int OFFSET_LSB = 0;
    localparam int OFFSET_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE,
        ERROR
    } state_t;

    function automatic logic is_itype(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/lc2k_field_packer.sv
// Combinational packing of LC2K instruction fields into a 32-bit machine word.
module lc2k_field_packer
    import lc2k_pkg::*;
(
    input  logic [2:0]  opcode,
    input  logic [2:0]  reg_a,
    input  logic [2:0]  reg_b,
    input  logic [2:0]  dest,
    input  logic [15:0] offset,
    output logic [31:0] word
);

    always_comb begin
        word = '0;
        word[OPCODE_LSB +: OPCODE_W] = opcode;
        case (opcode)
            OP_ADD, OP_NOR: begin
                word[REGA_LSB +: REG_W] = reg_a;
                word[REGB_LSB +: REG_W] = reg_b;
                word[DEST_LSB +: REG_W] = dest;
            end
            OP_LW, OP_SW, OP_BEQ: begin
                word[REGA_LSB +: REG_W]      = reg_a;
                word[REGB_LSB +: REG_W]      = reg_b;
                word[OFFSET_LSB +: OFFSET_W] = offset;
            end
            OP_JALR: begin
                word[REGA_LSB +: REG_W] = reg_a;
                word[REGB_LSB +: REG_W] = reg_b;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lc2k_inst_encoder.sv
// Streams LC2K instruction fields into encoded words written to memory until halt.
// Optional ENCODER_RANGE_CHECK_EN aborts the load on an I-type offset that does not fit 16 bits.
module lc2k_inst_encoder
    import lc2k_pkg::*;
#(
    parameter int MAX_WORDS = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_opcode,
    input  logic [2:0]  in_regA,
    input  logic [2:0]  in_regB,
    input  logic [2:0]  in_dest,
    input  logic [31:0] in_offset,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        done,
    output logic        err,
    output logic [31:0] word_count
);

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    state_t      state, state_nx;
    logic [31:0] word;
    logic        range_bad;
    logic        wr_is_halt;

    lc2k_field_packer u_packer (
        .opcode (in_opcode),
        .reg_a  (in_regA),
        .reg_b  (in_regB),
        .dest   (in_dest),
        .offset (in_offset[15:0]),
        .word   (word)
    );

`ifdef ENCODER_RANGE_CHECK_EN
    // Fits in 16 signed bits only when the upper 17 bits are all sign copies.
    assign range_bad = is_itype(in_opcode) && !((&in_offset[31:15]) || ~|in_offset[31:15]);
`else
    logic unused_offset_hi;
    assign unused_offset_hi = &{1'b0, in_offset[31:16]};
    assign range_bad = 1'b0;
`endif

    assign wr_is_halt = (mem_wdata[OPCODE_LSB +: OPCODE_W] == OP_HALT);

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = ACCEPT;
            end
            ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = range_bad ? ERROR : WRITE;
            end
            WRITE: begin
                mem_we = 1'b1;
                if (mem_ack) begin
                    if (wr_is_halt)                      state_nx = DONE;
                    else if (word_count + 32'd1 == MAX_W) state_nx = ERROR;
                    else                                 state_nx = ACCEPT;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nx = ACCEPT;
            end
            ERROR: begin
                err = 1'b1;
                if (start) state_nx = ACCEPT;
            end
            default: state_nx = IDLE;
        endcase
    end

    // mem_addr doubles as the running load address; it only moves on an acked write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        mem_addr   <= base_addr;
                        word_count <= '0;
                    end
                end
                ACCEPT: begin
                    if (in_valid && !range_bad) mem_wdata <= word;
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_addr   <= mem_addr + 32'd1;
                        word_count <= word_count + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lc2k_inst_encoder.sv
// Scoreboard bench for lc2k_inst_encoder; a second instance with MAX_WORDS=2 covers the size limit.
module tb_lc2k_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, mem_ack;
    logic [31:0] base_addr, in_offset;
    logic [2:0]  in_opcode, in_regA, in_regB, in_dest;
    logic        in_ready, mem_we, done, err;
    logic [31:0] mem_addr, mem_wdata, word_count;
    logic        in_ready2, mem_we2, done2, err2;
    logic [31:0] mem_addr2, mem_wdata2, word_count2;

    always #5 clk = ~clk;

    lc2k_inst_encoder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_regA(in_regA), .in_regB(in_regB), .in_dest(in_dest), .in_offset(in_offset),
        .mem_we(mem_we), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .done(done), .err(err), .word_count(word_count)
    );

    lc2k_inst_encoder #(.MAX_WORDS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready2), .in_opcode(in_opcode),
        .in_regA(in_regA), .in_regB(in_regB), .in_dest(in_dest), .in_offset(in_offset),
        .mem_we(mem_we2), .mem_ack(mem_ack), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .done(done2), .err(err2), .word_count(word_count2)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] exp_addr;
    logic [31:0] exp_wc;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                        input logic [2:0] d, input logic [31:0] off);
        logic [31:0] w;
        w = 32'(op) * 32'h0040_0000;
        if (op <= 3'd1)      w = w + 32'(a) * 32'h8_0000 + 32'(b) * 32'h1_0000 + 32'(d);
        else if (op <= 3'd4) w = w + 32'(a) * 32'h8_0000 + 32'(b) * 32'h1_0000 + (off % 32'h1_0000);
        else if (op == 3'd5) w = w + 32'(a) * 32'h8_0000 + 32'(b) * 32'h1_0000;
        return w;
    endfunction

    // Memory-side monitor: checks held values while waiting and pops the scoreboard on ack.
    logic        hold_v = 1'b0;
    logic [31:0] hold_a, hold_d;
    always @(negedge clk) begin
        if (!rst_n || !mem_we) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_addr", mem_addr, hold_a);
                chk("hold_data", mem_wdata, hold_d);
            end
            if (mem_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", mem_addr, 32'hxxxx_xxxx);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", mem_addr, e.a);
                    chk("wr_data", mem_wdata, e.d);
                end
                hold_v = 1'b0;
            end else begin
                hold_v = 1'b1;
                hold_a = mem_addr;
                hold_d = mem_wdata;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b);
        start = 1'b1;
        base_addr = b;
        cyc();
        start = 1'b0;
        exp_addr = b;
        exp_wc = 0;
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!in_ready && n < 20) begin
            cyc();
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] d, input logic [31:0] off, input logic [31:0] expd,
                        input bit wr, input int dly);
        wait_rdy();
        in_valid = 1'b1;
        in_opcode = op; in_regA = a; in_regB = b; in_dest = d; in_offset = off;
        if (wr) begin
            exp_q.push_back('{exp_addr, expd});
            exp_addr = exp_addr + 32'd1;
            exp_wc = exp_wc + 32'd1;
        end
        cyc();
        in_valid = 1'b0;
        if (wr) begin
            chk("latency_we", 32'(mem_we), 32'd1);
            repeat (dly) cyc();
            mem_ack = 1'b1;
            cyc();
            mem_ack = 1'b0;
        end
    endtask

    initial begin
        logic [2:0] op;
        logic [2:0] ra, rb, rd;
        logic [31:0] off;
        int dly;

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
        base_addr = '0; in_offset = '0; in_opcode = '0; in_regA = '0; in_regB = '0; in_dest = '0;
        exp_addr = '0; exp_wc = '0;
        cyc(); cyc();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_word_count", word_count, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("idle_no_ready", 32'(in_ready), 32'd0);

        // add, stray ack in ACCEPT, then halt with a slow ack
        do_start(32'h100);
        chk("start_wc", word_count, 32'd0);
        chk("start_ready", 32'(in_ready), 32'd1);
        send(3'd0, 3'd1, 3'd2, 3'd3, 32'd0, 32'h000A_0003, 1'b1, 0);
        chk("add_wc", word_count, 32'd1);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("stray_ack_wc", word_count, 32'd1);
        chk("stray_ack_addr", mem_addr, 32'h101);
        send(3'd6, 3'd0, 3'd0, 3'd0, 32'd0, 32'h0180_0000, 1'b1, 3);
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_ready", 32'(in_ready), 32'd0);
        chk("halt_wc", word_count, 32'd2);

        // restart from DONE; start while in ACCEPT must be ignored
        do_start(32'h200);
        chk("restart_done_clr", 32'(done), 32'd0);
        chk("restart_wc", word_count, 32'd0);
        send(3'd2, 3'd0, 3'd1, 3'd0, 32'd5, 32'h0081_0005, 1'b1, 0);
        start = 1'b1; base_addr = 32'h500;
        cyc();
        start = 1'b0;
        send(3'd4, 3'd0, 3'd0, 3'd0, 32'hFFFF_FFFF, 32'h0100_FFFF, 1'b1, 1);
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 6));
            if (op == 3'd6) op = 3'd7;
            ra = 3'($urandom_range(0, 7)); rb = 3'($urandom_range(0, 7)); rd = 3'($urandom_range(0, 7));
            off = 32'($urandom_range(0, 65535)) - 32'd32768;
            dly = int'($urandom_range(0, 2));
            send(op, ra, rb, rd, off, enc(op, ra, rb, rd, off), 1'b1, dly);
        end
        chk("random_wc", word_count, exp_wc);

        // out-of-range branch offset
`ifdef ENCODER_RANGE_CHECK_EN
        send(3'd4, 3'd0, 3'd0, 3'd0, 32'd40000, 32'h0, 1'b0, 0);
        chk("range_err", 32'(err), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("range_no_we", 32'(mem_we), 32'd0);
            cyc();
        end
        chk("range_wc", word_count, exp_wc);
        do_start(32'h300);
`else
        send(3'd4, 3'd0, 3'd0, 3'd0, 32'd40000, 32'h0100_9C40, 1'b1, 0);
        chk("trunc_err", 32'(err), 32'd0);
        chk("trunc_wc", word_count, exp_wc);
`endif

        // reset while a write is outstanding
        wait_rdy();
        in_valid = 1'b1; in_opcode = 3'd7;
        cyc();
        in_valid = 1'b0;
        chk("pre_rst_we", 32'(mem_we), 32'd1);
        cyc();
        rst_n = 1'b0;
        exp_q.delete();
        cyc();
        chk("wrst_mem_we", 32'(mem_we), 32'd0);
        chk("wrst_wc", word_count, 32'd0);
        chk("wrst_ready", 32'(in_ready), 32'd0);
        chk("wrst_done_err", {30'd0, done, err}, 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("wrst_idle", 32'(in_ready), 32'd0);

        // size limit on dut2, address wrap on both
        do_start(32'hFFFF_FFFF);
        send(3'd7, 3'd0, 3'd0, 3'd0, 32'd0, 32'h01C0_0000, 1'b1, 0);
        chk("max_first_err", 32'(err2), 32'd0);
        send(3'd7, 3'd0, 3'd0, 3'd0, 32'd0, 32'h01C0_0000, 1'b1, 0);
        chk("max_err", 32'(err2), 32'd1);
        chk("max_wc", word_count2, 32'd2);
        chk("max_ready", 32'(in_ready2), 32'd0);
        chk("big_no_err", 32'(err), 32'd0);
        chk("big_wc", word_count, 32'd2);
        chk("wrap_addr", mem_addr, 32'd1);
        send(3'd6, 3'd0, 3'd0, 3'd0, 32'd0, 32'h0180_0000, 1'b1, 0);
        chk("wrap_done", 32'(done), 32'd1);
        chk("max_err_held", 32'(err2), 32'd1);
        chk("max_no_we", 32'(mem_we2), 32'd0);

        cyc();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
